// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: FSM states and grant identity.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LD  = 1'b1
    } grant_t;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin picker for the SRAM port: CPU versus program loader.
// Holds the identity of the last winner so a tie goes to the other side.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic   Clk,
    input  logic   Reset,
    input  logic   req_cpu,
    input  logic   req_ld,
    input  logic   take,
    output logic   any_req,
    output grant_t pick
);

    grant_t last_grant;

    // Winner selection: a sole requester wins, a tie goes to whoever was not served last.
    always_comb begin
        // NOTE: every output is assigned on every path, so no latch is inferred.
        any_req = req_cpu | req_ld;
        pick    = GNT_CPU;
        if (req_cpu && req_ld) begin
            pick = (last_grant == GNT_LD) ? GNT_CPU : GNT_LD;
        end else if (req_ld) begin
            pick = GNT_LD;
        end
    end

    // Remember the last winner; reset favours the CPU on the first tie.
    always_ff @(posedge Clk) begin
        // NOTE: registered state always uses non-blocking assignments.
        if (!Reset) begin
            last_grant <= GNT_LD;
        end else if (take && any_req) begin
            last_grant <= pick;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM port between the CPU and the loader. Each access is a
// fixed-length cycle: strobe low for WAIT_CYCLES, capture read data as the
// strobe is released, then a one-cycle done pulse to the winner.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
)
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_done,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_wdata,
    output logic [15:0] ld_rdata,
    output logic        ld_done,
    output logic [15:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    input  logic [15:0] Data_from_SRAM,
    output logic        OE_N,
    output logic        WE_N,
    output logic        busy
);

    localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_we;
    grant_t           owner;
    logic             any_req;
    grant_t           pick;
    logic             take;

    assign take = (state == IDLE);
    assign busy = (state != IDLE);

    rr_arb2 u_rr_arb2 (
        .Clk     (Clk),
        .Reset   (Reset),
        .req_cpu (cpu_req),
        .req_ld  (ld_req),
        .take    (take),
        .any_req (any_req),
        .pick    (pick)
    );

    // Access sequencer: grant and latch, hold strobe for WAIT_CYCLES, capture, pulse done.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            // NOTE: the address/data/rdata registers are reset as well, since their zero value is visible at the ports.
            state        <= IDLE;
            cnt          <= '0;
            op_we        <= 1'b0;
            owner        <= GNT_CPU;
            ADDR         <= '0;
            Data_to_SRAM <= '0;
            OE_N         <= 1'b1;
            WE_N         <= 1'b1;
            cpu_done     <= 1'b0;
            ld_done      <= 1'b0;
            cpu_rdata    <= '0;
            ld_rdata     <= '0;
        end else begin
            cpu_done <= 1'b0;
            ld_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= pick;
                        cnt   <= CNT_LOAD;
                        state <= ACCESS;
                        if (pick == GNT_CPU) begin
                            op_we        <= cpu_we;
                            ADDR         <= cpu_addr;
                            Data_to_SRAM <= cpu_wdata;
                            OE_N         <= cpu_we;
                            WE_N         <= !cpu_we;
                        end else begin
                            op_we        <= ld_we;
                            ADDR         <= ld_addr;
                            Data_to_SRAM <= ld_wdata;
                            OE_N         <= ld_we;
                            WE_N         <= !ld_we;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        OE_N     <= 1'b1;
                        WE_N     <= 1'b1;
                        state    <= DONE;
                        cpu_done <= (owner == GNT_CPU);
                        ld_done  <= (owner == GNT_LD);
                        if (!op_we) begin
                            if (owner == GNT_CPU) begin
                                cpu_rdata <= Data_from_SRAM;
                            end else begin
                                ld_rdata <= Data_from_SRAM;
                            end
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with WAIT_CYCLES=2: directed scenarios
// followed by randomized traffic checked against a transaction-level model.
module tb_sram_arbiter;

    localparam int WAIT = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_done;
    logic        ld_req = 1'b0, ld_we = 1'b0;
    logic [15:0] ld_addr = '0, ld_wdata = '0;
    logic [15:0] ld_rdata;
    logic        ld_done;
    logic [15:0] ADDR, Data_to_SRAM, Data_from_SRAM;
    logic        OE_N, WE_N, busy;

    int total = 0;
    int bad   = 0;

    // Behavioural SRAM (16 words, low address bits) with a backdoor for preloading.
    logic [15:0] sram_mem [16];
    logic        bd_en = 1'b0;
    logic [3:0]  bd_addr = '0;
    logic [15:0] bd_data = '0;

    always @(posedge Clk) begin
        if (bd_en) sram_mem[bd_addr] <= bd_data;
        else if (!WE_N) sram_mem[ADDR[3:0]] <= Data_to_SRAM;
    end
    assign Data_from_SRAM = sram_mem[ADDR[3:0]];

    always #5 Clk = ~Clk;

    sram_arbiter #(.WAIT_CYCLES(WAIT)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_done(ld_done),
        .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
        .OE_N(OE_N), .WE_N(WE_N), .busy(busy)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        step();
        step();
        Reset = 1'b1;
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        bd_en = 1'b1; bd_addr = a; bd_data = d;
        step();
        bd_en = 1'b0;
    endtask

    task automatic test_reset();
        cpu_req = 1'b1; ld_req = 1'b1;
        Reset = 1'b0;
        step();
        step();
        total++; if (OE_N !== 1'b1) begin bad++; $display("FAIL reset_oe_n: got %b want 1", OE_N); end
        total++; if (WE_N !== 1'b1) begin bad++; $display("FAIL reset_we_n: got %b want 1", WE_N); end
        total++; if (cpu_done !== 1'b0 || ld_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b%b want 00", cpu_done, ld_done); end
        total++; if (cpu_rdata !== 16'h0 || ld_rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata: got %h/%h want 0000/0000", cpu_rdata, ld_rdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (ADDR !== 16'h0 || Data_to_SRAM !== 16'h0) begin bad++; $display("FAIL reset_addr: got %h/%h want 0000/0000", ADDR, Data_to_SRAM); end
        cpu_req = 1'b0; ld_req = 1'b0;
        Reset = 1'b1;
        step();
    endtask

    task automatic test_cpu_read();
        int oe_cnt = 0, we_cnt = 0, done_cnt = 0, ld_cnt = 0, done_at = -1;
        logic addr_ok = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005; cpu_wdata = 16'h5555;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (!OE_N) begin oe_cnt++; if (ADDR !== 16'h0005) addr_ok = 1'b0; end
            if (!WE_N) we_cnt++;
            if (ld_done) ld_cnt++;
            if (cpu_done) begin done_cnt++; if (done_at < 0) done_at = i; cpu_req = 1'b0; end
        end
        total++; if (oe_cnt !== 2) begin bad++; $display("FAIL rd_oe_cycles: got %0d want 2", oe_cnt); end
        total++; if (we_cnt !== 0) begin bad++; $display("FAIL rd_we_cycles: got %0d want 0", we_cnt); end
        total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL rd_addr: ADDR not 0005 during strobe"); end
        total++; if (done_cnt !== 1 || ld_cnt !== 0) begin bad++; $display("FAIL rd_done_count: got cpu=%0d ld=%0d want 1/0", done_cnt, ld_cnt); end
        total++; if (done_at !== 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", done_at); end
        total++; if (cpu_rdata !== 16'h1234) begin bad++; $display("FAIL rd_data: got %h want 1234", cpu_rdata); end
    endtask

    task automatic test_ld_write();
        int oe_cnt = 0, we_cnt = 0, done_cnt = 0;
        logic data_ok = 1'b1;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0010; ld_wdata = 16'hBEEF;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 1) begin ld_addr = 16'h0003; ld_wdata = 16'h0000; end
            if (!OE_N) oe_cnt++;
            if (!WE_N) begin
                we_cnt++;
                if (Data_to_SRAM !== 16'hBEEF || ADDR !== 16'h0010) data_ok = 1'b0;
            end
            if (ld_done) begin done_cnt++; ld_req = 1'b0; end
        end
        total++; if (we_cnt !== 2) begin bad++; $display("FAIL wr_we_cycles: got %0d want 2", we_cnt); end
        total++; if (oe_cnt !== 0) begin bad++; $display("FAIL wr_oe_cycles: got %0d want 0", oe_cnt); end
        total++; if (data_ok !== 1'b1) begin bad++; $display("FAIL wr_data: ADDR/Data_to_SRAM not 0010/BEEF during strobe"); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL wr_done_count: got %0d want 1", done_cnt); end
        total++; if (sram_mem[0] !== 16'hBEEF) begin bad++; $display("FAIL wr_mem: got %h want BEEF", sram_mem[0]); end
        total++; if (ld_rdata !== 16'h0) begin bad++; $display("FAIL wr_rdata_kept: got %h want 0000", ld_rdata); end
    endtask

    task automatic test_round_robin();
        logic who [4];
        int   when [4];
        int   n = 0;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0010; ld_wdata = 16'hBEEF;
        for (int j = 0; j < 4; j++) begin who[j] = 1'bx; when[j] = -1; end
        for (int i = 1; i <= 20; i++) begin
            step();
            if (cpu_done && n < 4) begin who[n] = 1'b0; when[n] = i; n++; end
            if (ld_done && n < 4) begin who[n] = 1'b1; when[n] = i; n++; end
        end
        cpu_req = 1'b0; ld_req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            total++;
            if (who[j] !== 1'(j % 2) || when[j] !== 3 + 4 * j) begin
                bad++;
                $display("FAIL rr_grant%0d: got who=%b cycle=%0d want who=%b cycle=%0d", j, who[j], when[j], 1'(j % 2), 3 + 4 * j);
            end
        end
        step(); step();
    endtask

    task automatic test_reset_mid_access();
        int done_cnt = 0;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        step();
        step();
        total++; if (OE_N !== 1'b0) begin bad++; $display("FAIL mid_strobe_before: got %b want 0", OE_N); end
        Reset = 1'b0; cpu_req = 1'b0;
        step();
        total++; if (OE_N !== 1'b1 || WE_N !== 1'b1) begin bad++; $display("FAIL mid_strobe_release: got %b%b want 11", OE_N, WE_N); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (cpu_done) done_cnt++;
        Reset = 1'b1;
        for (int i = 0; i < 6; i++) begin step(); if (cpu_done || ld_done) done_cnt++; end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL mid_no_done: got %0d want 0", done_cnt); end
        total++; if (cpu_rdata !== 16'h0) begin bad++; $display("FAIL mid_rdata: got %h want 0000", cpu_rdata); end
    endtask

    task automatic test_req_drop();
        int done_cnt = 0, oe_cnt = 0, busy_after = -1, done_at = -1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 1) cpu_req = 1'b0;
            if (!OE_N) oe_cnt++;
            if (cpu_done) begin done_cnt++; done_at = i; end
            if (done_at > 0 && i == done_at + 1) busy_after = int'(busy);
        end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL drop_done_count: got %0d want 1", done_cnt); end
        total++; if (oe_cnt !== 2) begin bad++; $display("FAIL drop_oe_cycles: got %0d want 2", oe_cnt); end
        total++; if (busy_after !== 0) begin bad++; $display("FAIL drop_busy_after: got %0d want 0", busy_after); end
        total++; if (cpu_rdata !== 16'h1234) begin bad++; $display("FAIL drop_rdata: got %h want 1234", cpu_rdata); end
    endtask

    // Random traffic against a transaction-level model: grants follow the
    // arbitration rules, timing follows the fixed access length.
    task automatic test_random();
        logic [15:0] model_mem [16];
        logic [15:0] exp_cpu_rdata = '0, exp_ld_rdata = '0;
        logic [15:0] g_addr = '0, g_wdata = '0, g_rd = '0, v;
        logic        g_we = 1'b0, win = 1'b0, last = 1'b1, active = 1'b0;
        logic        s_cpu_req, s_ld_req, s_cpu_we, s_ld_we;
        logic [15:0] s_cpu_addr, s_ld_addr, s_cpu_wdata, s_ld_wdata;
        logic        e_strobe, e_done, e_busy;
        int          free_at = 0, g_edge = 0, grants = 0;

        do_reset();
        for (int i = 0; i < 16; i++) begin
            v = 16'($urandom);
            model_mem[i] = v;
            preload(4'(i), v);
        end

        for (int k = 0; k < 800; k++) begin
            @(posedge Clk);
            s_cpu_req = cpu_req; s_cpu_we = cpu_we; s_cpu_addr = cpu_addr; s_cpu_wdata = cpu_wdata;
            s_ld_req = ld_req; s_ld_we = ld_we; s_ld_addr = ld_addr; s_ld_wdata = ld_wdata;
            if (k >= free_at && (s_cpu_req || s_ld_req)) begin
                win     = (s_cpu_req && s_ld_req) ? ~last : s_ld_req;
                last    = win;
                g_edge  = k;
                free_at = k + WAIT + 2;
                active  = 1'b1;
                grants++;
                g_we    = win ? s_ld_we : s_cpu_we;
                g_addr  = win ? s_ld_addr : s_cpu_addr;
                g_wdata = win ? s_ld_wdata : s_cpu_wdata;
                if (g_we) model_mem[g_addr[3:0]] = g_wdata;
                else g_rd = model_mem[g_addr[3:0]];
            end
            #1;
            e_strobe = active && k >= g_edge && k <= g_edge + WAIT - 1;
            e_done   = active && k == g_edge + WAIT;
            e_busy   = active && k <= g_edge + WAIT;
            if (e_done && !g_we) begin
                if (win) exp_ld_rdata = g_rd;
                else exp_cpu_rdata = g_rd;
            end
            total++; if (OE_N !== !(e_strobe && !g_we)) begin bad++; $display("FAIL rnd_oe_n @%0d: got %b want %b", k, OE_N, !(e_strobe && !g_we)); end
            total++; if (WE_N !== !(e_strobe && g_we)) begin bad++; $display("FAIL rnd_we_n @%0d: got %b want %b", k, WE_N, !(e_strobe && g_we)); end
            total++; if (cpu_done !== (e_done && !win)) begin bad++; $display("FAIL rnd_cpu_done @%0d: got %b want %b", k, cpu_done, e_done && !win); end
            total++; if (ld_done !== (e_done && win)) begin bad++; $display("FAIL rnd_ld_done @%0d: got %b want %b", k, ld_done, e_done && win); end
            total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy @%0d: got %b want %b", k, busy, e_busy); end
            total++; if (cpu_rdata !== exp_cpu_rdata) begin bad++; $display("FAIL rnd_cpu_rdata @%0d: got %h want %h", k, cpu_rdata, exp_cpu_rdata); end
            total++; if (ld_rdata !== exp_ld_rdata) begin bad++; $display("FAIL rnd_ld_rdata @%0d: got %h want %h", k, ld_rdata, exp_ld_rdata); end
            if (e_strobe) begin
                total++; if (ADDR !== g_addr) begin bad++; $display("FAIL rnd_addr @%0d: got %h want %h", k, ADDR, g_addr); end
                if (g_we) begin
                    total++; if (Data_to_SRAM !== g_wdata) begin bad++; $display("FAIL rnd_wdata @%0d: got %h want %h", k, Data_to_SRAM, g_wdata); end
                end
            end
            // Requesters hold req until their done, then may leave or re-request.
            if (e_done && !win) cpu_req = 1'($urandom_range(0, 1));
            else if (!cpu_req) cpu_req = ($urandom_range(0, 2) == 0);
            if (e_done && win) ld_req = 1'($urandom_range(0, 1));
            else if (!ld_req) ld_req = ($urandom_range(0, 2) == 0);
            cpu_we = 1'($urandom); cpu_addr = 16'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
            ld_we  = 1'($urandom); ld_addr  = 16'($urandom_range(0, 15)); ld_wdata  = 16'($urandom);
        end
        total++; if (grants < 50) begin bad++; $display("FAIL rnd_activity: got %0d grants want >=50", grants); end
        cpu_req = 1'b0; ld_req = 1'b0;
        for (int i = 0; i < WAIT + 3; i++) step();
    endtask

    initial begin
        test_reset();
        preload(4'h5, 16'h1234);
        test_cpu_read();
        test_ld_write();
        test_round_robin();
        test_reset_mid_access();
        test_req_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
